regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters:
  - the in-order pipeline writeback stage (WB);
  - the multi-cycle mult/div unit (MD), which completes out of band.
- WB has priority. MD results queue in a small FIFO and drain on idle WB cycles.
- A starvation counter forces a one-cycle WB stall so MD results always retire.
- Sits between the writeback stage/multdiv unit and the regfile write inputs.

Parameters:
- MD_DEPTH, 2, number of MD result entries buffered (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive cycles a live MD head may be blocked before WB is stalled (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wb_we  in  1  WB write request this cycle.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- md_valid  in  1  MD result valid.
- md_ready  out  1  FIFO can accept an MD result.
- md_rd  in  5  MD destination register.
- md_data  in  32  MD result.
- ctrl_writeEnable  out  1  regfile write enable (registered).
- ctrl_writeReg  out  5  regfile write address (registered).
- data_writeReg  out  32  regfile write data (registered).
- wb_stall  out  1  WB must hold its instruction; arbiter ignores wb_we this cycle (registered).
- pending_mask  out  32  bit r set if a live queued MD entry targets register r.

Behaviour:
- Reset (reset=0, async):
  - FIFO empty; starvation counter = 0.
  - ctrl_writeEnable = 0, ctrl_writeReg = 0, data_writeReg = 0.
  - wb_stall = 0, pending_mask = 0, md_ready = 1.
  - A reset mid-queue discards all entries.
- MD handshake:
  - Enqueue on the rising edge with md_valid & md_ready.
  - md_ready = (count < MD_DEPTH), combinational from state only.
  - md_data/md_rd are held by MD while not accepted.
- Entry format: {live, rd, data}. An entry with rd = 0 enqueues as dead.
- Port selection each cycle, first match wins:
  - wb_stall=0 & wb_we=1 & wb_rd≠0 → WB write.
  - else FIFO non-empty → dequeue head; write only if the head is live.
  - else no write.
- wb_we with wb_rd=0: no write, but the port is still considered used by WB.
- Latency:
  - WB request in cycle N → regfile write in cycle N+1.
  - MD handshake in cycle N → earliest write in cycle N+2.
  - FIFO order is preserved.
- WAW kill: an accepted WB write to rd X clears live on every queued entry with rd X. This includes an entry enqueued on the same edge; it enters dead.
- Dead entries dequeue in one cycle with ctrl_writeEnable=0.
- Simultaneous enqueue and dequeue when full: not permitted, because md_ready uses the pre-edge count.
- Simultaneous enqueue and dequeue when non-full: both occur; count unchanged.
- Starvation counter:
  - Increments each cycle the head is live and WB takes the port.
  - Clears when the head dequeues or the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, wb_stall is registered to 1 for exactly one cycle and the counter clears.
  - In the wb_stall cycle the head dequeues regardless of wb_we.
- pending_mask: OR of one-hot(rd) over live entries; bit 0 is always 0.

Optional Feature:
- Macro: RSTATUS_EXC_EN.
- When defined:
  - Adds input md_exc (1 bit) and input md_exc_code (32 bits), sampled with the MD handshake.
  - An entry with md_exc=1 is redirected to rd=30 with data=md_exc_code, always live.
  - The WAW kill then compares against 30.
- When undefined: these ports do not exist and all entries use md_rd/md_data.

Test Plan:
- Reset with entries queued:
  - Stimulus: assert reset low mid-queue.
  - Required: outputs 0 immediately; md_ready=1; pending_mask=0.
- MD only:
  - Stimulus: md_valid with rd=5, data=0x0000_0042 at cycle 0; WB idle.
  - Required: md_ready=1; write r5=0x42 in cycle 2; pending_mask bit 5 set in cycle 1 only.
- Priority and full condition:
  - Stimulus: WB writes r3 every cycle; MD enqueues r7 then r8.
  - Required: md_ready=0 once 2 entries are queued; no MD write until WB idles.
  - Required on WB idle: r7 then r8 in consecutive cycles.
- WAW kill:
  - Stimulus: queue r9=0x11, then WB writes r9=0x22.
  - Required: the head dequeues with no write; r9 is written only with 0x22; pending_mask bit 9 clears.
- Starvation (STARVE_LIMIT=8):
  - Stimulus: continuous WB writes with a live head queued.
  - Required: wb_stall high for one cycle after 8 blocked cycles; the head writes in that cycle; WB resumes next cycle.
- RSTATUS_EXC_EN defined:
  - Stimulus: MD rd=4, md_exc=1, code=0x0000_0003.
  - Required: write r30=3; r4 unchanged.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Shares the single regfile write port between the WB stage (priority) and a small mult/div result FIFO.
// Optional RSTATUS_EXC_EN: excepting MD results are redirected to r30 carrying the exception code.
module regfile_write_arbiter #(
   parameter int MD_DEPTH     = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        md_valid,
   output logic        md_ready,
   input  logic [4:0]  md_rd,
   input  logic [31:0] md_data,
`ifdef RSTATUS_EXC_EN
   input  logic        md_exc,
   input  logic [31:0] md_exc_code,
`endif
   output logic        ctrl_writeEnable,
   output logic [4:0]  ctrl_writeReg,
   output logic [31:0] data_writeReg,
   output logic        wb_stall,
   output logic [31:0] pending_mask
);
   localparam int PTR_W    = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
   localparam int CNT_W    = $clog2(MD_DEPTH + 1);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [MD_DEPTH-1:0] ent_live;
   logic [4:0]          ent_rd   [MD_DEPTH];
   logic [31:0]         ent_data [MD_DEPTH];
   logic [PTR_W-1:0]    rd_ptr, wr_ptr;
   logic [CNT_W-1:0]    count;
   logic [STARVE_W-1:0] starve_cnt;

   logic [4:0]  enq_rd;
   logic [31:0] enq_data;
   logic        fifo_empty, wb_owns, wb_write, deq, enq, head_live, starve_hit;
   logic        wr_en_p0;
   logic [4:0]  wr_reg_p0;
   logic [31:0] wr_data_p0;

`ifdef RSTATUS_EXC_EN
   assign enq_rd   = md_exc ? 5'd30 : md_rd;
   assign enq_data = md_exc ? md_exc_code : md_data;
`else
   assign enq_rd   = md_rd;
   assign enq_data = md_data;
`endif

   assign md_ready   = (count < CNT_W'(MD_DEPTH));
   assign fifo_empty = (count == '0);
   // A WB request with rd=0 still occupies the port; it just never writes.
   assign wb_owns    = !wb_stall && wb_we;
   assign wb_write   = wb_owns && (wb_rd != 5'd0);
   assign deq        = !wb_owns && !fifo_empty;
   assign enq        = md_valid && md_ready;
   assign head_live  = !fifo_empty && ent_live[rd_ptr];
   assign starve_hit = head_live && wb_owns && (starve_cnt == STARVE_W'(STARVE_LIMIT - 1));

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < MD_DEPTH; i++)
         if (ent_live[i]) pending_mask[ent_rd[i]] = 1'b1;
      pending_mask[0] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ent_live <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         // An accepted WB write supersedes any queued result for the same register.
         for (int i = 0; i < MD_DEPTH; i++)
            if (wb_write && (ent_rd[i] == wb_rd)) ent_live[i] <= 1'b0;
         if (deq) begin
            ent_live[rd_ptr] <= 1'b0;
            rd_ptr           <= rd_ptr + 1'b1;
         end
         if (enq) begin
            ent_live[wr_ptr] <= (enq_rd != 5'd0) && !(wb_write && (enq_rd == wb_rd));
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (enq && !deq)      count <= count + 1'b1;
         else if (!enq && deq) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (enq) begin
         ent_rd[wr_ptr]   <= enq_rd;
         ent_data[wr_ptr] <= enq_data;
      end
   end

   // stage 0: port selection
   always_comb begin
      wr_en_p0   = 1'b0;
      wr_reg_p0  = 5'd0;
      wr_data_p0 = 32'd0;
      if (wb_write) begin
         wr_en_p0   = 1'b1;
         wr_reg_p0  = wb_rd;
         wr_data_p0 = wb_data;
      end else if (deq && head_live) begin
         wr_en_p0   = 1'b1;
         wr_reg_p0  = ent_rd[rd_ptr];
         wr_data_p0 = ent_data[rd_ptr];
      end
   end

   // stage 1: registered regfile write port and starvation control
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= 5'd0;
         data_writeReg    <= 32'd0;
         wb_stall         <= 1'b0;
         starve_cnt       <= '0;
      end else begin
         ctrl_writeEnable <= wr_en_p0;
         ctrl_writeReg    <= wr_reg_p0;
         data_writeReg    <= wr_data_p0;
         wb_stall         <= starve_hit;
         if (deq || fifo_empty || starve_hit)
            starve_cnt <= '0;
         else if (head_live && wb_owns)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, hand-built corner sequences, randomized run vs queue model.
module tb_regfile_write_arbiter;
   localparam int MD_DEPTH     = 2;
   localparam int STARVE_LIMIT = 8;
   localparam int N_TBL        = 20;
   localparam int N_RAND       = 1500;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        md_valid = 1'b0;
   logic        md_ready;
   logic [4:0]  md_rd = '0;
   logic [31:0] md_data = '0;
`ifdef RSTATUS_EXC_EN
   logic        md_exc = 1'b0;
   logic [31:0] md_exc_code = '0;
`endif
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        wb_stall;
   logic [31:0] pending_mask;

   regfile_write_arbiter #(.MD_DEPTH(MD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clock            (clock),
      .reset            (reset),
      .wb_we            (wb_we),
      .wb_rd            (wb_rd),
      .wb_data          (wb_data),
      .md_valid         (md_valid),
      .md_ready         (md_ready),
      .md_rd            (md_rd),
      .md_data          (md_data),
`ifdef RSTATUS_EXC_EN
      .md_exc           (md_exc),
      .md_exc_code      (md_exc_code),
`endif
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .wb_stall         (wb_stall),
      .pending_mask     (pending_mask)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        stall;
      logic        ready;
      logic [31:0] mask;
   } obs_t;

   typedef struct {
      bit          wb_we;
      bit [4:0]    wb_rd;
      bit [31:0]   wb_data;
      bit          md_valid;
      bit [4:0]    md_rd;
      bit [31:0]   md_data;
      obs_t        exp;
   } vec_t;

   typedef struct packed {
      bit        live;
      bit [4:0]  rd;
      bit [31:0] data;
   } ent_t;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: the queue holds pending MD results in arrival order.
   ent_t      q[$];
   bit        m_we;
   bit [4:0]  m_reg;
   bit [31:0] m_data;
   bit        m_stall;
   int        m_starve;

   function automatic void model_reset();
      q.delete();
      m_we = 0; m_reg = 0; m_data = 0; m_stall = 0; m_starve = 0;
   endfunction

   function automatic void model_step();
      bit        wb_port   = wb_we && !m_stall;
      bit        wb_wr     = wb_port && (wb_rd != 0);
      bit        was_ready = (q.size() < MD_DEPTH);
      bit        hd_live   = (q.size() > 0) && q[0].live;
      bit        nstall    = 0;
      bit [4:0]  erd       = md_rd;
      bit [31:0] edat      = md_data;
      ent_t      e;
`ifdef RSTATUS_EXC_EN
      if (md_exc) begin erd = 5'd30; edat = md_exc_code; end
`endif
      m_we = 0; m_reg = 0; m_data = 0;
      if (wb_port) begin
         if (wb_wr) begin
            m_we = 1; m_reg = wb_rd; m_data = wb_data;
            for (int i = 0; i < q.size(); i++) begin
               e = q[i];
               if (e.rd == wb_rd) e.live = 0;
               q[i] = e;
            end
         end
         if (q.size() == 0) m_starve = 0;
         else if (hd_live) begin
            m_starve++;
            if (m_starve == STARVE_LIMIT) begin nstall = 1; m_starve = 0; end
         end
      end else if (q.size() > 0) begin
         e = q.pop_front();
         if (e.live) begin m_we = 1; m_reg = e.rd; m_data = e.data; end
         m_starve = 0;
      end else m_starve = 0;
      if (md_valid && was_ready) begin
         e.live = (erd != 0) && !(wb_wr && wb_rd == erd);
         e.rd   = erd;
         e.data = edat;
         q.push_back(e);
      end
      m_stall = nstall;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.we = m_we; o.rd = m_reg; o.data = m_data; o.stall = m_stall;
      o.ready = (q.size() < MD_DEPTH);
      o.mask = '0;
      foreach (q[i]) if (q[i].live) o.mask[q[i].rd] = 1'b1;
      o.mask[0] = 1'b0;
      return o;
   endfunction

   function automatic obs_t mk(bit we, int rd, int data, bit stall, bit rdy, int mask);
      obs_t o;
      o.we = we; o.rd = 5'(rd); o.data = 32'(data); o.stall = stall; o.ready = rdy; o.mask = 32'(mask);
      return o;
   endfunction

   function automatic vec_t row(bit we, int wrd, int wdat, bit mv, int mrd, int mdat, obs_t e);
      vec_t v;
      v.wb_we = we; v.wb_rd = 5'(wrd); v.wb_data = 32'(wdat);
      v.md_valid = mv; v.md_rd = 5'(mrd); v.md_data = 32'(mdat); v.exp = e;
      return v;
   endfunction

   function automatic void check(string name, obs_t exp);
      obs_t act;
      act.we = ctrl_writeEnable; act.rd = ctrl_writeReg; act.data = data_writeReg;
      act.stall = wb_stall; act.ready = md_ready; act.mask = pending_mask;
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t: got we=%b rd=%0d data=%h stall=%b ready=%b mask=%h; expected we=%b rd=%0d data=%h stall=%b ready=%b mask=%h",
                  name, $time, act.we, act.rd, act.data, act.stall, act.ready, act.mask,
                  exp.we, exp.rd, exp.data, exp.stall, exp.ready, exp.mask);
      end
   endfunction

   task automatic tick();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic drive(bit we, int wrd, int wdat, bit mv, int mrd, int mdat);
      wb_we = we; wb_rd = 5'(wrd); wb_data = 32'(wdat);
      md_valid = mv; md_rd = 5'(mrd); md_data = 32'(mdat);
   endtask

   vec_t tbl[N_TBL];

   initial begin
      bit acc;
      tbl[0]  = row(0,  0, 'h00, 1,  5, 'h42, mk(0,  0, 'h00, 0, 1, 'h000));
      tbl[1]  = row(0,  0, 'h00, 0,  0, 'h00, mk(0,  0, 'h00, 0, 1, 'h020));
      tbl[2]  = row(0,  0, 'h00, 0,  0, 'h00, mk(1,  5, 'h42, 0, 1, 'h000));
      tbl[3]  = row(1,  3, 'hA0, 1,  7, 'h70, mk(0,  0, 'h00, 0, 1, 'h000));
      tbl[4]  = row(1,  3, 'hA1, 1,  8, 'h80, mk(1,  3, 'hA0, 0, 1, 'h080));
      tbl[5]  = row(1,  3, 'hA2, 0,  0, 'h00, mk(1,  3, 'hA1, 0, 0, 'h180));
      tbl[6]  = row(1,  3, 'hA3, 0,  0, 'h00, mk(1,  3, 'hA2, 0, 0, 'h180));
      tbl[7]  = row(0,  0, 'h00, 0,  0, 'h00, mk(1,  3, 'hA3, 0, 0, 'h180));
      tbl[8]  = row(0,  0, 'h00, 0,  0, 'h00, mk(1,  7, 'h70, 0, 1, 'h100));
      tbl[9]  = row(0,  0, 'h00, 1,  9, 'h11, mk(1,  8, 'h80, 0, 1, 'h000));
      tbl[10] = row(1,  9, 'h22, 0,  0, 'h00, mk(0,  0, 'h00, 0, 1, 'h200));
      tbl[11] = row(0,  0, 'h00, 0,  0, 'h00, mk(1,  9, 'h22, 0, 1, 'h000));
      tbl[12] = row(0,  0, 'h00, 1,  6, 'h66, mk(0,  0, 'h00, 0, 1, 'h000));
      tbl[13] = row(1,  0, 'h55, 0,  0, 'h00, mk(0,  0, 'h00, 0, 1, 'h040));
      tbl[14] = row(0,  0, 'h00, 0,  0, 'h00, mk(0,  0, 'h00, 0, 1, 'h040));
      tbl[15] = row(0,  0, 'h00, 1,  0, 'h77, mk(1,  6, 'h66, 0, 1, 'h000));
      tbl[16] = row(0,  0, 'h00, 0,  0, 'h00, mk(0,  0, 'h00, 0, 1, 'h000));
      tbl[17] = row(1, 12, 'h12, 1, 12, 'h34, mk(0,  0, 'h00, 0, 1, 'h000));
      tbl[18] = row(0,  0, 'h00, 0,  0, 'h00, mk(1, 12, 'h12, 0, 1, 'h000));
      tbl[19] = row(0,  0, 'h00, 0,  0, 'h00, mk(0,  0, 'h00, 0, 1, 'h000));

      model_reset();
      repeat (3) @(posedge clock);
      #1;
      check("reset_state", mk(0, 0, 0, 0, 1, 0));
      reset = 1'b1;

      for (int k = 0; k < N_TBL; k++) begin
         check($sformatf("vec%0d", k), tbl[k].exp);
         drive(tbl[k].wb_we, int'(tbl[k].wb_rd), int'(tbl[k].wb_data),
               tbl[k].md_valid, int'(tbl[k].md_rd), int'(tbl[k].md_data));
         tick();
      end

      acc = 1'b1;
      for (int k = 0; k < N_RAND; k++) begin
         check($sformatf("rand%0d", k), model_obs());
         wb_we   = ($urandom_range(0, 99) < (((k / 150) % 2 == 0) ? 95 : 40));
         wb_rd   = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         if (!(md_valid && !acc)) begin
            md_valid = ($urandom_range(0, 1) == 1);
            md_rd    = 5'($urandom_range(0, 7));
            md_data  = $urandom;
`ifdef RSTATUS_EXC_EN
            md_exc      = ($urandom_range(0, 7) == 0);
            md_exc_code = $urandom;
`endif
         end
         acc = md_valid && md_ready;
         tick();
      end
`ifdef RSTATUS_EXC_EN
      md_exc = 1'b0;
`endif

      for (int k = 0; k < 3; k++) begin
         drive(1, 3, 'h500 + k, 1, 10, 'hAA);
         tick();
         check($sformatf("prereset%0d", k), model_obs());
      end
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check("reset_midqueue", mk(0, 0, 0, 0, 1, 0));
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clock);
      #1;
      check("reset_held", mk(0, 0, 0, 0, 1, 0));
      reset = 1'b1;

      for (int k = 0; k < 12; k++) begin
         obs_t e;
         if (k == 0)       e = mk(0, 0, 0, 0, 1, 0);
         else if (k <= 9)  e = mk(1, 3, 'h300 + k - 1, (k == 9), 1, 'h80);
         else if (k == 10) e = mk(1, 7, 'h77, 0, 1, 0);
         else              e = mk(1, 3, 'h300 + 10, 0, 1, 0);
         check($sformatf("starve%0d", k), e);
         drive(1, 3, 'h300 + k, (k == 0), 7, 'h77);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      check("idle_after_starve", model_obs());

`ifdef RSTATUS_EXC_EN
      drive(0, 0, 0, 1, 4, 'h1234);
      md_exc = 1'b1; md_exc_code = 32'h3;
      tick();
      md_exc = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      check("exc_pending", mk(0, 0, 0, 0, 1, 32'h4000_0000));
      tick();
      check("exc_write_r30", mk(1, 30, 3, 0, 1, 0));
      tick();
      check("exc_no_r4", mk(0, 0, 0, 0, 1, 0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
